// File: rtl/timer_cap_cmp_if.sv
// timer_cap_cmp_if: register-file side bundle of the capture/compare timer.
// The master drives the static configuration and capture pins; the slave
// (the timer core) returns the count, the captured values and interrupts.
interface timer_cap_cmp_if #(
    parameter int timer_width = 16,
    parameter int chn_n       = 2
);
    logic                         timer_ce;
    logic                         timer_started;
    logic                         timer_down;
    logic [timer_width-1:0]       prescale;
    logic [timer_width-1:0]       autoload;
    logic                         timer_cnt_to_set;
    logic [timer_width-1:0]       timer_cnt_set_v;
    logic [timer_width-1:0]       timer_cnt_now_v;
    logic                         timer_expired;
    logic                         timer_expired_itr_req;
    logic [chn_n-1:0]             chn_mode;
    logic [chn_n*timer_width-1:0] chn_cmp_v;
    logic [2*chn_n-1:0]           chn_cap_edge;
    logic [chn_n-1:0]             chn_cap_in;
    logic [chn_n*timer_width-1:0] chn_cap_v;
    logic [chn_n-1:0]             chn_cmp_out;
    logic [chn_n-1:0]             chn_itr_req;

    modport master (
        output timer_ce, timer_started, timer_down, prescale, autoload,
               timer_cnt_to_set, timer_cnt_set_v, chn_mode, chn_cmp_v,
               chn_cap_edge, chn_cap_in,
        input  timer_cnt_now_v, timer_expired, timer_expired_itr_req,
               chn_cap_v, chn_cmp_out, chn_itr_req
    );

    modport slave (
        input  timer_ce, timer_started, timer_down, prescale, autoload,
               timer_cnt_to_set, timer_cnt_set_v, chn_mode, chn_cmp_v,
               chn_cap_edge, chn_cap_in,
        output timer_cnt_now_v, timer_expired, timer_expired_itr_req,
               chn_cap_v, chn_cmp_out, chn_itr_req
    );
endinterface

// File: rtl/timer_cap_cmp.sv
// timer_cap_cmp: prescaled auto-reload up/down counter with chn_n channels,
// each either a registered compare (PWM) output or an edge-triggered capture.
// Prescale, auto-reload and compare values pass through shadow registers that
// only reload while stopped or at counter expiry, so mid-period writes apply
// from the next period.
// Build option: define TIMER_CAP_FILTER_EN to add a 4-sample glitch filter
// after each capture synchroniser (capture latency grows from 3 to 6 clk).
module timer_cap_cmp #(
    parameter int timer_width      = 16,
    parameter int chn_n            = 2,
    parameter int simulation_delay = 1
) (
    input  logic           clk,
    input  logic           rst,
    timer_cap_cmp_if.slave bus
);

    typedef logic [timer_width-1:0] word_t;

    word_t prescale_cnt_q, prescale_cnt_d;
    word_t prescale_shadow_q, prescale_shadow_d;
    word_t autoload_shadow_q, autoload_shadow_d;
    word_t count_q, count_d;
    logic  expired_itr_q, expired_itr_d;

    logic [chn_n-1:0][timer_width-1:0] cmp_shadow_q, cmp_shadow_d;
    logic [chn_n-1:0][timer_width-1:0] cap_v_q, cap_v_d;
    logic [chn_n-1:0][timer_width-1:0] cmp_v_in;

    logic [chn_n-1:0] sync1_q, sync1_d;
    logic [chn_n-1:0] sync2_q, sync2_d;
    logic [chn_n-1:0] cmp_out_q, cmp_out_d;
    logic [chn_n-1:0] chn_itr_q, chn_itr_d;
    logic [chn_n-1:0] lvl_now, lvl_prev, edge_hit;

`ifdef TIMER_CAP_FILTER_EN
    logic [chn_n-1:0][2:0] hist_q, hist_d;
    logic [chn_n-1:0]      filt_q, filt_d;
`else
    logic [chn_n-1:0]      prev_q, prev_d;
`endif

    logic tick, bd, expired, update;

    // simulation_delay has no effect on synthesised flops; it stays so that
    // existing instantiations overriding it still elaborate.
    if (simulation_delay < 0) begin : g_negative_delay
    end

    // Tick is gated by rst so the combinational expiry output is quiet in reset.
    assign cmp_v_in = bus.chn_cmp_v;
    assign tick     = ~rst & bus.timer_started & bus.timer_ce
                      & (prescale_cnt_q == prescale_shadow_q);
    assign bd       = bus.timer_down ? (count_q == '0) : (count_q == autoload_shadow_q);
    assign expired  = tick & bd;
    assign update   = ~bus.timer_started | expired;

    // Timer datapath: prescaler, shadow reloads and the up/down counter.
    always_comb begin
        prescale_cnt_d    = prescale_cnt_q;
        prescale_shadow_d = prescale_shadow_q;
        autoload_shadow_d = autoload_shadow_q;
        cmp_shadow_d      = cmp_shadow_q;
        count_d           = count_q;
        expired_itr_d     = expired;

        if (!bus.timer_started) begin
            prescale_cnt_d = '0;
        end else if (bus.timer_ce) begin
            prescale_cnt_d = (prescale_cnt_q == prescale_shadow_q) ? '0
                                                                   : prescale_cnt_q + word_t'(1);
        end

        if (update) begin
            prescale_shadow_d = bus.prescale;
            autoload_shadow_d = bus.autoload;
            cmp_shadow_d      = cmp_v_in;
        end

        if (bus.timer_cnt_to_set) begin
            count_d = bus.timer_cnt_set_v;
        end else if (tick) begin
            if (bd) begin
                count_d = bus.timer_down ? autoload_shadow_q : '0;
            end else begin
                count_d = bus.timer_down ? count_q - word_t'(1) : count_q + word_t'(1);
            end
        end
    end

    // Channels: input synchronisers, edge detection, capture, compare and interrupts.
    always_comb begin
        sync1_d   = bus.chn_cap_in;
        sync2_d   = sync1_q;
        cap_v_d   = cap_v_q;
        cmp_out_d = '0;
        chn_itr_d = '0;
        edge_hit  = '0;
`ifdef TIMER_CAP_FILTER_EN
        hist_d = hist_q;
        filt_d = filt_q;
        for (int k = 0; k < chn_n; k++) begin
            hist_d[k] = {hist_q[k][1:0], sync2_q[k]};
            if (hist_q[k] == {3{sync2_q[k]}}) begin
                filt_d[k] = sync2_q[k];
            end
        end
        lvl_now  = filt_d;
        lvl_prev = filt_q;
`else
        prev_d   = sync2_q;
        lvl_now  = sync2_q;
        lvl_prev = prev_q;
`endif
        for (int k = 0; k < chn_n; k++) begin
            case (bus.chn_cap_edge[2*k +: 2])
                2'b00:   edge_hit[k] = lvl_now[k] & ~lvl_prev[k];
                2'b01:   edge_hit[k] = ~lvl_now[k] & lvl_prev[k];
                2'b10:   edge_hit[k] = lvl_now[k] ^ lvl_prev[k];
                default: edge_hit[k] = 1'b0;
            endcase
            if (bus.chn_mode[k]) begin
                if (edge_hit[k]) begin
                    cap_v_d[k]   = count_q;
                    chn_itr_d[k] = 1'b1;
                end
            end else begin
                cmp_out_d[k] = bus.timer_started & (count_q < cmp_shadow_q[k]);
                chn_itr_d[k] = tick & (count_q == cmp_shadow_q[k]);
            end
        end
    end

    // State registers; everything clears asynchronously while rst is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale_cnt_q    <= '0;
            prescale_shadow_q <= '0;
            autoload_shadow_q <= '0;
            count_q           <= '0;
            expired_itr_q     <= 1'b0;
            cmp_shadow_q      <= '0;
            cap_v_q           <= '0;
            sync1_q           <= '0;
            sync2_q           <= '0;
            cmp_out_q         <= '0;
            chn_itr_q         <= '0;
`ifdef TIMER_CAP_FILTER_EN
            hist_q            <= '0;
            filt_q            <= '0;
`else
            prev_q            <= '0;
`endif
        end else begin
            prescale_cnt_q    <= prescale_cnt_d;
            prescale_shadow_q <= prescale_shadow_d;
            autoload_shadow_q <= autoload_shadow_d;
            count_q           <= count_d;
            expired_itr_q     <= expired_itr_d;
            cmp_shadow_q      <= cmp_shadow_d;
            cap_v_q           <= cap_v_d;
            sync1_q           <= sync1_d;
            sync2_q           <= sync2_d;
            cmp_out_q         <= cmp_out_d;
            chn_itr_q         <= chn_itr_d;
`ifdef TIMER_CAP_FILTER_EN
            hist_q            <= hist_d;
            filt_q            <= filt_d;
`else
            prev_q            <= prev_d;
`endif
        end
    end

    assign bus.timer_cnt_now_v       = count_q;
    assign bus.timer_expired         = expired;
    assign bus.timer_expired_itr_req = expired_itr_q;
    assign bus.chn_cap_v             = cap_v_q;
    assign bus.chn_cmp_out           = cmp_out_q;
    assign bus.chn_itr_req           = chn_itr_q;

endmodule

// File: tb/tb_timer_cap_cmp.sv
// tb_timer_cap_cmp: directed bench for timer_cap_cmp (default build, no filter).
// Expected interrupt events are queued ahead of each phase; a monitor pops one
// entry per observed pulse and compares source and value.
`timescale 1ns/1ps
module tb_timer_cap_cmp;

    localparam int TW = 16;
    localparam int CN = 2;

    logic clk = 1'b0;
    logic rst;

    timer_cap_cmp_if #(.timer_width(TW), .chn_n(CN)) bus ();

    timer_cap_cmp #(
        .timer_width(TW),
        .chn_n(CN),
        .simulation_delay(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // 10 ns clock; stimulus and sampling happen on the falling edge.
    always #5 clk = ~clk;

    // Event sources: 0 expiry, 1 channel 0 (count shown), 2 channel 1 (capture shown).
    typedef struct {
        int            src;
        logic [TW-1:0] val;
    } event_t;

    event_t exp_q[$];
    int     n_checks = 0;
    int     n_fails  = 0;

    int up_cnt[10]  = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 0};
    int up_pwm[10]  = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    int down_cnt[8] = '{3, 2, 2, 1, 0, 3, 2, 1};

    // Single comparison with reporting.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive the static configuration seen by the timer.
    task automatic applyStimulus(input logic started, input logic down, input int presc,
                                 input int reload, input logic [1:0] mode,
                                 input logic [3:0] edge_sel, input int cmp0);
        bus.timer_started          = started;
        bus.timer_down             = down;
        bus.prescale               = TW'(presc);
        bus.autoload               = TW'(reload);
        bus.chn_mode               = mode;
        bus.chn_cap_edge           = edge_sel;
        bus.chn_cmp_v[TW-1:0]      = TW'(cmp0);
        bus.chn_cmp_v[2*TW-1:TW]   = '0;
    endtask

    task automatic expectEvent(input int src, input int val);
        event_t e;
        e.src = src;
        e.val = TW'(val);
        exp_q.push_back(e);
    endtask

    task automatic scoreEvent(input int src, input logic [TW-1:0] val);
        event_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fails++;
            $display("[TB] FAIL unexpected_event: got src %0d value %0d, expected no event", src, val);
        end else begin
            e = exp_q.pop_front();
            if (e.src != src || e.val !== val) begin
                n_fails++;
                $display("[TB] FAIL event: got src %0d value %0d, expected src %0d value %0d",
                         src, val, e.src, e.val);
            end
        end
    endtask

    // Monitor: every interrupt pulse consumes one queued expectation.
    always @(negedge clk) begin
        if (bus.timer_expired_itr_req === 1'b1) scoreEvent(0, bus.timer_cnt_now_v);
        if (bus.chn_itr_req[0] === 1'b1)        scoreEvent(1, bus.timer_cnt_now_v);
        if (bus.chn_itr_req[1] === 1'b1)        scoreEvent(2, bus.chn_cap_v[2*TW-1:TW]);
    end

    // Watchdog so the run always ends.
    initial begin
        #50000;
        $display("[TB] FAIL watchdog: got timeout, expected normal end");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst                  = 1'b1;
        bus.timer_ce         = 1'b1;
        bus.timer_cnt_to_set = 1'b0;
        bus.timer_cnt_set_v  = '0;
        bus.chn_cap_in       = '0;
        applyStimulus(1'b1, 1'b0, 1, 4, 2'b10, 4'b1111, 2);

        // Reset state, with the timer enabled so expiry gating is exercised.
        @(negedge clk);
        checkOutput("rst_count",       bus.timer_cnt_now_v, 0);
        checkOutput("rst_expired",     bus.timer_expired, 0);
        checkOutput("rst_expired_itr", bus.timer_expired_itr_req, 0);
        checkOutput("rst_cmp_out",     bus.chn_cmp_out, 0);
        checkOutput("rst_chn_itr",     bus.chn_itr_req, 0);
        checkOutput("rst_cap_v",       bus.chn_cap_v, 0);
        bus.timer_started = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Up count, prescale 1, autoload 4, ch0 compare 2 then 4 mid-period.
        $display("[TB] phase up-count / compare");
        expectEvent(1, 3);
        expectEvent(0, 0);
        expectEvent(1, 3);
        expectEvent(0, 0);
        expectEvent(0, 0);
        expectEvent(1, 0);
        bus.timer_started = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i <= 10) begin
                checkOutput($sformatf("up_count_%0d", i), bus.timer_cnt_now_v, up_cnt[i-1]);
                checkOutput($sformatf("up_pwm_%0d", i), bus.chn_cmp_out[0], up_pwm[i-1]);
            end
            if (i == 8) checkOutput("up_expired_8", bus.timer_expired, 0);
            if (i == 9) checkOutput("up_expired_9", bus.timer_expired, 1);
            if (i == 12) bus.chn_cmp_v[TW-1:0] = TW'(4);
            if (i == 16) checkOutput("cmp_old_shadow", bus.chn_cmp_out[0], 0);
            if (i == 26) checkOutput("cmp_new_shadow", bus.chn_cmp_out[0], 1);
        end

        // Down count, prescale 0, autoload 3, load 2 against a same-cycle tick.
        $display("[TB] phase down-count / load");
        applyStimulus(1'b0, 1'b1, 0, 3, 2'b10, 4'b1111, 4);
        repeat (2) @(negedge clk);
        expectEvent(0, 3);
        expectEvent(0, 3);
        bus.timer_started = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            checkOutput($sformatf("down_count_%0d", i), bus.timer_cnt_now_v, down_cnt[i-1]);
            if (i == 2) begin
                bus.timer_cnt_to_set = 1'b1;
                bus.timer_cnt_set_v  = TW'(2);
            end
            if (i == 3) bus.timer_cnt_to_set = 1'b0;
            if (i == 4) checkOutput("down_expired_4", bus.timer_expired, 0);
            if (i == 5) checkOutput("down_expired_5", bus.timer_expired, 1);
        end

        // Capture on ch1: rising edge, disabled edge, then falling edge while stopped.
        $display("[TB] phase capture");
        applyStimulus(1'b0, 1'b0, 0, 100, 2'b11, 4'b0011, 4);
        bus.timer_cnt_to_set = 1'b1;
        bus.timer_cnt_set_v  = '0;
        @(negedge clk);
        bus.timer_cnt_to_set = 1'b0;
        @(negedge clk);
        expectEvent(2, 9);
        expectEvent(2, 20);
        bus.timer_started = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            if (i == 3) checkOutput("cap_mode_pwm_forced", bus.chn_cmp_out[0], 0);
            if (i == 7) begin
                checkOutput("cap_count_7", bus.timer_cnt_now_v, 7);
                bus.chn_cap_in[1] = 1'b1;
            end
            if (i == 9) checkOutput("cap_before_latency", bus.chn_cap_v[2*TW-1:TW], 0);
            if (i == 10) begin
                checkOutput("cap_rising", bus.chn_cap_v[2*TW-1:TW], 9);
                bus.chn_cap_edge = 4'b1111;
            end
            if (i == 11) bus.chn_cap_in[1] = 1'b0;
            if (i == 14) bus.chn_cap_in[1] = 1'b1;
            if (i == 20) begin
                checkOutput("cap_edge_off", bus.chn_cap_v[2*TW-1:TW], 9);
                checkOutput("cap_count_20", bus.timer_cnt_now_v, 20);
                bus.timer_started = 1'b0;
                bus.chn_cap_edge  = 4'b0111;
            end
            if (i == 22) bus.chn_cap_in[1] = 1'b0;
            if (i == 24) checkOutput("cap_fall_pending", bus.chn_cap_v[2*TW-1:TW], 9);
            if (i == 25) begin
                checkOutput("cap_fall_stopped", bus.chn_cap_v[2*TW-1:TW], 20);
                checkOutput("cap_frozen_count", bus.timer_cnt_now_v, 20);
            end
        end

        // Asynchronous reset mid-run, then recovery from zero.
        $display("[TB] phase async reset");
        applyStimulus(1'b0, 1'b0, 0, 100, 2'b10, 4'b0111, 8);
        bus.timer_cnt_to_set = 1'b1;
        bus.timer_cnt_set_v  = '0;
        @(negedge clk);
        bus.timer_cnt_to_set = 1'b0;
        @(negedge clk);
        bus.timer_started = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("prerst_count",   bus.timer_cnt_now_v, 5);
        checkOutput("prerst_cmp_out", bus.chn_cmp_out[0], 1);
        rst = 1'b1;
        #1;
        checkOutput("arst_count",       bus.timer_cnt_now_v, 0);
        checkOutput("arst_cmp_out",     bus.chn_cmp_out, 0);
        checkOutput("arst_cap_v",       bus.chn_cap_v, 0);
        checkOutput("arst_expired",     bus.timer_expired, 0);
        checkOutput("arst_expired_itr", bus.timer_expired_itr_req, 0);
        checkOutput("arst_chn_itr",     bus.chn_itr_req, 0);
        expectEvent(0, 0);
        expectEvent(1, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i <= 2; i++) begin
            @(negedge clk);
            checkOutput($sformatf("resume_count_%0d", i), bus.timer_cnt_now_v, i);
        end

        bus.timer_started = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
